// File: rtl/calc_pkg.sv
// Command/response codes, result record and bus widths shared by the calculator responder.
// Combinational definitions only; no latency or flow control.
package calc_pkg;

  localparam int CALC_DATA_W = 32;
  localparam int CALC_TAG_W  = 2;
  localparam int CALC_CMD_W  = 4;

  typedef enum logic [CALC_CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } calc_cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_INV  = 2'd3
  } calc_resp_e;

  typedef struct packed {
    calc_resp_e             resp;
    logic [CALC_TAG_W-1:0]  tag;
    logic [CALC_DATA_W-1:0] data;
  } calc_result_t;

  function automatic logic is_shift_cmd(input logic [CALC_CMD_W-1:0] cmd);
    return (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Calculator datapath: short class (add/sub/invalid) valid in the op2 cycle, shifts 2 cycles later.
// No backpressure; each result is offered for exactly one cycle. Shifter exists only with CALC_RESP_SHIFT_EN.
module calc_alu
  import calc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_vld,
  input  logic [CALC_CMD_W-1:0]  cmd,
  input  logic [CALC_TAG_W-1:0]  tag,
  input  logic [CALC_DATA_W-1:0] op1,
  input  logic [CALC_DATA_W-1:0] op2,
  output logic                   short_vld,
  output calc_result_t           short_dat,
  output logic                   long_vld,
  output calc_result_t           long_dat
);

  logic [CALC_DATA_W:0] sum;
  logic [CALC_DATA_W:0] diff;
  logic                 take_long;

  // The top bit of diff is the borrow, set exactly when op2 > op1 unsigned.
  always_comb begin
    sum       = {1'b0, op1} + {1'b0, op2};
    diff      = {1'b0, op1} - {1'b0, op2};
    short_dat = '{resp: RESP_INV, tag: tag, data: '0};
    case (cmd)
      CMD_ADD: begin
        short_dat.resp = sum[CALC_DATA_W] ? RESP_OVF : RESP_OK;
        short_dat.data = sum[CALC_DATA_W-1:0];
      end
      CMD_SUB: begin
        short_dat.resp = diff[CALC_DATA_W] ? RESP_OVF : RESP_OK;
        short_dat.data = diff[CALC_DATA_W-1:0];
      end
      default: ;
    endcase
  end

  assign short_vld = start_vld && !take_long;

`ifdef CALC_RESP_SHIFT_EN
  logic                   s1_vld;
  logic                   s1_left;
  logic [4:0]             s1_amt;
  logic [CALC_TAG_W-1:0]  s1_tag;
  logic [CALC_DATA_W-1:0] s1_data;
  logic                   s2_vld;
  logic                   s2_left;
  logic [2:0]             s2_amt;
  logic [CALC_TAG_W-1:0]  s2_tag;
  logic [CALC_DATA_W-1:0] s2_data;

  assign take_long = is_shift_cmd(cmd);

  // Two iterations: the byte-multiple part of the amount first, the remaining 0-7 bits on the way out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_left <= 1'b0;
      s1_amt  <= '0;
      s1_tag  <= '0;
      s1_data <= '0;
      s2_vld  <= 1'b0;
      s2_left <= 1'b0;
      s2_amt  <= '0;
      s2_tag  <= '0;
      s2_data <= '0;
    end else begin
      s1_vld <= start_vld && take_long;
      if (start_vld && take_long) begin
        s1_left <= (cmd == CMD_SHL);
        s1_amt  <= op2[4:0];
        s1_tag  <= tag;
        s1_data <= op1;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_left <= s1_left;
        s2_amt  <= s1_amt[2:0];
        s2_tag  <= s1_tag;
        s2_data <= s1_left ? (s1_data << {s1_amt[4:3], 3'b000})
                           : (s1_data >> {s1_amt[4:3], 3'b000});
      end
    end
  end

  assign long_vld = s2_vld;

  always_comb begin
    long_dat      = '0;
    long_dat.resp = RESP_OK;
    long_dat.tag  = s2_tag;
    long_dat.data = s2_left ? (s2_data << s2_amt) : (s2_data >> s2_amt);
  end
`else
  logic unused_shift_clk;

  assign take_long        = 1'b0;
  assign long_vld         = 1'b0;
  assign long_dat         = '0;
  assign unused_shift_clk = &{1'b0, clk, rst_n};
`endif

endmodule

// File: rtl/calc_port_responder.sv
// Calculator responder: frames cmd/op1 then op2, computes, queues results; short ops out at C+3, shifts (CALC_RESP_SHIFT_EN) at C+5.
// No backpressure: legal framing guarantees the response FIFO never fills; one entry drains per cycle.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:CALC_CMD_W-1]  req_cmd_in,
  input  logic [0:CALC_TAG_W-1]  req_tag_in,
  input  logic [0:CALC_DATA_W-1] req_data_in,
  output logic [0:1]             out_resp,
  output logic [0:CALC_TAG_W-1]  out_tag,
  output logic [0:CALC_DATA_W-1] out_data
);

  localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_OP2} frame_state_e;

  frame_state_e           state;
  logic [CALC_CMD_W-1:0]  cmd_q;
  logic [CALC_TAG_W-1:0]  tag_q;
  logic [CALC_DATA_W-1:0] op1_q;
  logic                   alu_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cmd_q <= '0;
      tag_q <= '0;
      op1_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_cmd_in != '0) begin
            state <= ST_OP2;
            cmd_q <= req_cmd_in;
            tag_q <= req_tag_in;
            op1_q <= req_data_in;
          end
        end
        ST_OP2:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // op2 is consumed straight off the bus in the OP2 cycle; the command field there is ignored.
  assign alu_start = (state == ST_OP2);

  logic         short_vld;
  logic         long_vld;
  calc_result_t short_dat;
  calc_result_t long_dat;

  calc_alu u_alu (
    .clk       (clk),
    .rst_n     (reset),
    .start_vld (alu_start),
    .cmd       (cmd_q),
    .tag       (tag_q),
    .op1       (op1_q),
    .op2       (req_data_in),
    .short_vld (short_vld),
    .short_dat (short_dat),
    .long_vld  (long_vld),
    .long_dat  (long_dat)
  );

  calc_result_t     fifo_mem [RESP_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic [1:0]       push_n;
  logic             fifo_pop;
  calc_result_t     out_q;

  assign push_n   = {1'b0, long_vld} + {1'b0, short_vld};
  assign fifo_pop = (fifo_cnt != '0);

  // A completing shift was always issued before a same-cycle short op, so it takes the lower slot.
  always_ff @(posedge clk) begin
    if (long_vld) begin
      fifo_mem[wr_ptr] <= long_dat;
    end
    if (short_vld) begin
      fifo_mem[wr_ptr + PTR_W'(long_vld)] <= short_dat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(push_n);
      fifo_cnt <= fifo_cnt + (PTR_W+1)'(push_n) - (PTR_W+1)'(fifo_pop);
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      out_q <= fifo_pop ? fifo_mem[rd_ptr] : '0;
    end
  end

  assign out_resp = out_q.resp;
  assign out_tag  = out_q.tag;
  assign out_data = out_q.data;

endmodule

// File: tb/tb_calc_port_responder.sv
// Randomized and directed bench for calc_port_responder against a queue-based response model.
module tb_calc_port_responder;

  localparam int DEPTH = 4;

`ifdef CALC_RESP_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [0:3]  req_cmd_in;
  logic [0:1]  req_tag_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:1]  out_tag;
  logic [0:31] out_data;

  always #5 clk = ~clk;

  calc_port_responder #(.RESP_FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_tag_in  (req_tag_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_tag     (out_tag),
    .out_data    (out_data)
  );

  typedef struct {
    int          due;
    logic [35:0] rsp;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [35:0] obs_log [0:8191];
  bit          in_op2 = 1'b0;
  logic [3:0]  p_cmd;
  logic [1:0]  p_tag;
  logic [31:0] p_op1;
  int          p_cyc;
  int          c0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // Response the protocol defines for one request: {resp, tag, data}.
  function automatic logic [35:0] ref_result(input logic [3:0] cmd, input logic [1:0] tag,
                                             input logic [31:0] a, input logic [31:0] b);
    longint unsigned wide;
    logic [1:0]      resp;
    logic [31:0]     data;
    int              amt;
    resp = 2'b11;
    data = 32'h0;
    amt  = int'(b % 32);
    case (cmd)
      4'd1: begin
        wide = 64'(a) + 64'(b);
        resp = (wide > 64'hFFFF_FFFF) ? 2'b10 : 2'b01;
        data = a + b;
      end
      4'd2: begin
        resp = (b > a) ? 2'b10 : 2'b01;
        data = a - b;
      end
      4'd5: if (SHIFT_EN) begin resp = 2'b01; data = a << amt; end
      4'd6: if (SHIFT_EN) begin resp = 2'b01; data = a >> amt; end
      default: ;
    endcase
    return {resp, tag, data};
  endfunction

  function automatic int lat_of(input logic [3:0] c);
    return (SHIFT_EN && (c == 4'd5 || c == 4'd6)) ? 5 : 3;
  endfunction

  task automatic sample_and_check();
    logic [35:0] want;
    logic [35:0] got;
    want = '0;
    got  = {out_resp, out_tag, out_data};
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      want = exp_q[0].rsp;
      void'(exp_q.pop_front());
    end
    check("out", 64'(got), 64'(want));
    check("fifo_full", 64'(dut.fifo_cnt == DEPTH), 64'(0));
    if (cyc < 8192) obs_log[cyc] = got;
  endtask

  task automatic step(input logic [3:0] cmd, input logic [1:0] tag, input logic [31:0] dat);
    @(posedge clk);
    #1;
    req_cmd_in  = cmd;
    req_tag_in  = tag;
    req_data_in = dat;
    if (in_op2) begin
      exp_q.push_back('{due: p_cyc + lat_of(p_cmd), rsp: ref_result(p_cmd, p_tag, p_op1, dat)});
      in_op2 = 1'b0;
    end else if (cmd != 4'd0) begin
      p_cmd  = cmd;
      p_tag  = tag;
      p_op1  = dat;
      p_cyc  = cyc;
      in_op2 = 1'b1;
    end
    @(negedge clk);
    sample_and_check();
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'd0, 2'd0, 32'h0);
  endtask

  task automatic reset_pulse(input string name);
    logic [35:0] want;
    @(posedge clk);
    #1;
    req_cmd_in  = '0;
    req_tag_in  = '0;
    req_data_in = '0;
    want = '0;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) want = exp_q[0].rsp;
    check({name, "_pre"}, 64'({out_resp, out_tag, out_data}), 64'(want));
    reset = 1'b0;
    #1;
    check({name, "_async"}, 64'({out_resp, out_tag, out_data}), 64'(0));
    #2;
    reset = 1'b1;
    exp_q.delete();
    in_op2 = 1'b0;
    @(negedge clk);
    sample_and_check();
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rc;
    logic [31:0] rd;
    int          v;
    reset       = 1'b1;
    req_cmd_in  = '0;
    req_tag_in  = '0;
    req_data_in = '0;
    #2 reset = 1'b0;
    #4;
    check("reset_state", 64'({out_resp, out_tag, out_data}), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    c0 = cyc; step(4'd1, 2'd2, 32'h5); step(4'd0, 2'd0, 32'h3); idle(5);
    check("add_basic", 64'(obs_log[c0+3]), {28'h0, 2'b01, 2'd2, 32'h0000_0008});
    check("add_hold_1cyc", 64'(obs_log[c0+4]), 64'(0));

    c0 = cyc; step(4'd1, 2'd1, 32'hFFFF_FFFF); step(4'd0, 2'd0, 32'h1); idle(5);
    check("add_carry", 64'(obs_log[c0+3]), {28'h0, 2'b10, 2'd1, 32'h0000_0000});

    c0 = cyc; step(4'd2, 2'd0, 32'h3); step(4'd0, 2'd0, 32'h5); idle(5);
    check("sub_borrow", 64'(obs_log[c0+3]), {28'h0, 2'b10, 2'd0, 32'hFFFF_FFFE});

    c0 = cyc; step(4'd5, 2'd1, 32'h1); step(4'd0, 2'd0, 32'h24); idle(7);
`ifdef CALC_RESP_SHIFT_EN
    check("shl_amt4", 64'(obs_log[c0+5]), {28'h0, 2'b01, 2'd1, 32'h0000_0010});
`else
    check("shl_invalid", 64'(obs_log[c0+3]), {28'h0, 2'b11, 2'd1, 32'h0000_0000});
`endif

    c0 = cyc; step(4'd6, 2'd0, 32'h80); step(4'd0, 2'd0, 32'h3);
    step(4'd1, 2'd3, 32'h1); step(4'd0, 2'd0, 32'h1); idle(6);
`ifdef CALC_RESP_SHIFT_EN
    check("collide_shift_first", 64'(obs_log[c0+5]), {28'h0, 2'b01, 2'd0, 32'h0000_0010});
    check("collide_add_second", 64'(obs_log[c0+6]), {28'h0, 2'b01, 2'd3, 32'h0000_0002});
    check("collide_then_idle", 64'(obs_log[c0+7]), 64'(0));
`else
    check("shr_invalid", 64'(obs_log[c0+3]), {28'h0, 2'b11, 2'd0, 32'h0000_0000});
    check("add_after_shr", 64'(obs_log[c0+5]), {28'h0, 2'b01, 2'd3, 32'h0000_0002});
    check("add_after_idle", 64'(obs_log[c0+6]), 64'(0));
`endif

    c0 = cyc; step(4'hF, 2'd3, 32'h1234); step(4'd1, 2'd2, 32'h5678); idle(6);
    check("invalid_cmd", 64'(obs_log[c0+3]), {28'h0, 2'b11, 2'd3, 32'h0000_0000});
    check("op2_cmd_ignored_a", 64'(obs_log[c0+4]), 64'(0));
    check("op2_cmd_ignored_b", 64'(obs_log[c0+5]), 64'(0));

    step(4'd1, 2'd1, 32'h10); step(4'd0, 2'd0, 32'h20); reset_pulse("rst_add_c2"); idle(8);
    step(4'd6, 2'd2, 32'hF0); step(4'd0, 2'd0, 32'h4); reset_pulse("rst_shift_c2"); idle(8);
    step(4'd2, 2'd3, 32'h9); step(4'd0, 2'd0, 32'h4); idle(1); reset_pulse("rst_visible_c3"); idle(8);

    repeat (1500) begin
      if (in_op2) begin
        rc = 4'($urandom_range(0, 15));
      end else begin
        v = $urandom_range(0, 9);
        if (v < 3)       rc = 4'd0;
        else if (v < 5)  rc = 4'd1;
        else if (v < 7)  rc = 4'd2;
        else if (v == 7) rc = 4'd5;
        else if (v == 8) rc = 4'd6;
        else begin
          v  = $urandom_range(0, 10);
          rc = (v < 2) ? 4'(v + 3) : 4'(v + 5);
        end
      end
      case ($urandom_range(0, 3))
        0:       rd = $urandom;
        1:       rd = 32'($urandom_range(0, 40));
        2:       rd = 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
        default: rd = $urandom;
      endcase
      step(rc, 2'($urandom_range(0, 3)), rd);
    end
    idle(10);
    check("model_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_port_responder.md
# calc_port_responder

Responder end of the single-port calculator request/response protocol. It accepts a command, tag and two operands driven on the request bus, computes the result, and returns a tagged response on the output bus. It is the DUV-side counterpart of the stimulus port; the scoreboard and checker observe it.

## Interface
- Parameters:
- `RESP_FIFO_DEPTH`, default 4: number of completed results buffered awaiting output. Must be a power of 2 and at least 2.
- Ports:
- `clk`, input, 1: single clock. Everything is rising-edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req_cmd_in`, input, [0:3]: command. 0 = nop, 1 = add, 2 = sub, 5 = shift left, 6 = shift right. All other values are invalid.
- `req_tag_in`, input, [0:1]: request tag. Sampled in the command cycle only.
- `req_data_in`, input, [0:31]: operand 1 in the command cycle, operand 2 in the following cycle.
- `out_resp`, output, [0:1]: 00 = no response, 01 = success, 10 = overflow/underflow, 11 = invalid command.
- `out_tag`, output, [0:1]: tag of the current response.
- `out_data`, output, [0:31]: result. Zero unless `out_resp` is 01 or 10.
- Bit 0 is the MSB on every bus.

## Operation
- Request framing:
  - The command cycle is C: `req_cmd_in` is nonzero; the block captures cmd, tag and op1.
  - In C+1 the block captures op2 from `req_data_in`. `req_cmd_in` in C+1 is ignored, even if nonzero.
  - The next command is accepted no earlier than C+2.
- Add: 33-bit sum. Carry-out gives resp 10 with `out_data` = truncated 32-bit sum. Otherwise resp 01.
- Sub: op1 - op2. If op2 > op1 (unsigned), resp 10 with `out_data` = truncated difference. Otherwise resp 01.
- Shift left/right: logical shift. The amount is op2[27:31], so 0 to 31. Always resp 01.
- Invalid command: resp 11, `out_data` = 0. The invalid command still consumes its op2 cycle.
- Pipeline class:
  - Add, sub and invalid are in the short class.
  - Shifts are in the long class. They take 2 extra cycles in a dedicated iterative shifter stage.
- Completion pushes the result into the response FIFO.
  - Up to 2 pushes are allowed per cycle.
  - On a same-cycle collision, the older request (the earlier command cycle) gets the lower FIFO slot.
- FIFO pop: one entry per cycle while non-empty. The popped entry drives the output registers.
- FIFO full: cannot occur under legal framing. The bench asserts it is never hit.
- The block does no duplicate-tag checking. Responses carry whatever tag was captured.

## Timing
- Reset values: `out_resp`, `out_tag` and `out_data` are all 0. The FIFO is empty, all in-flight requests are discarded, and the framing state machine is in IDLE.
- Framing state machine:
  - IDLE → OP2 when `req_cmd_in` != 0.
  - OP2 → IDLE unconditionally after capturing op2.
- Short-class latency: the response is visible on outputs in cycle C+3 when the FIFO is empty.
- Long-class latency: response in C+5.
- A response is held for exactly 1 cycle. `out_resp` returns to 00 the next cycle unless another entry pops.
- Collision example: shift at C=0 and add at C=2 both complete in the same cycle. The shift appears at cycle 5 and the add at cycle 6.
- Reset asserted mid-operation: outputs clear asynchronously and no partial response is ever emitted after reset deasserts.

## Configuration
- `CALC_RESP_SHIFT_EN` defined: shift commands 5 and 6 execute as specified, and the shifter stage is present.
- `CALC_RESP_SHIFT_EN` undefined:
  - The shifter is removed.
  - Commands 5 and 6 are treated as invalid: resp 11, short latency (C+3).
  - Collisions cannot occur.

## Structure
- Package `calc_pkg` holds:
  - the `calc_cmd_e` enum for command codes;
  - the `calc_resp_e` enum for response codes;
  - the `calc_result_t` struct (resp, tag, data);
  - width constants: `CALC_DATA_W` = 32, `CALC_TAG_W` = 2, `CALC_CMD_W` = 4.
- Sub-module `calc_alu`:
  - Covers the add/sub/invalid short path and the registered shift stage.
  - Outputs two `calc_result_t` streams with valid flags.
  - The top level holds the framing state machine, FIFO and output registers.

## Test plan
- Add 0x0000_0005 + 0x0000_0003, tag 2 → at C+3: resp 01, tag 2, data 0x0000_0008.
- Add 0xFFFF_FFFF + 0x0000_0001, tag 1 → resp 10, data 0x0000_0000. Sub 0x3 - 0x5 → resp 10, data 0xFFFF_FFFE.
- Shift left 0x0000_0001 by op2 = 0x0000_0024 (amount 4) → at C+5: resp 01, data 0x0000_0010. Without `CALC_RESP_SHIFT_EN`: resp 11 at C+3.
- Shift right (tag 0) at C=0, then add (tag 3) at C=2 → tag 0 at cycle 5, tag 3 at cycle 6, resp 00 at cycle 7.
- Command 0xF, tag 3 → C+3: resp 11, data 0. A nonzero `req_cmd_in` in the op2 cycle produces no extra response.
- Add issued, `reset` pulsed low in C+2 → outputs 0 immediately, and no response in any later cycle.
